// File: rtl/timer_ctrl_pkg.sv
// Shared register map and CTRL bit positions for the CPU interrupt timer.
package timer_ctrl_pkg;

  localparam logic [3:0] TMR_CTRL   = 4'h0;
  localparam logic [3:0] TMR_LIMIT  = 4'h4;
  localparam logic [3:0] TMR_COUNT  = 4'h8;
  localparam logic [3:0] TMR_STATUS = 4'hC;

  localparam int TMR_EN      = 0;
  localparam int TMR_ONESHOT = 1;
  localparam int TMR_IE      = 2;
  localparam int TMR_PS_LSB  = 8;

  // Registers are word-aligned, so only addr[3:2] distinguishes them.
  function automatic logic reg_hit(input logic [3:0] addr, input logic [3:0] offset);
    return addr[3:2] == offset[3:2];
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Single-cycle register port between the CPU MEM stage and the timer.
interface timer_ctrl_if;

  logic        cs;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output cs, output we, output addr, output wdata, input rdata);
  modport slave  (input cs, input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/timer_ctrl_prescaler.sv
// Prescaler: emits one tick every PRESCALE+1 enabled cycles.
module timer_prescaler #(
  parameter int PS_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [PS_W-1:0] prescale,
  output logic            tick
);

  logic [PS_W-1:0] ps_cnt;

  assign tick = en && (ps_cnt == prescale);

  // clr only arrives while en is still 0, so it never collides with a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt <= '0;
    end else if (clr) begin
      ps_cnt <= '0;
    end else if (en) begin
      ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Memory-mapped interrupt timer: config registers, prescaled counter,
// sticky W1C pending flag and level interrupt into the exception logic.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int               CNT_W     = 32,
  parameter int               PS_W      = 8,
  parameter logic [CNT_W-1:0] RST_LIMIT = CNT_W'(1000)
) (
  input  logic         clk,
  input  logic         reset,
  timer_ctrl_if.slave  bus,
  output logic         timer_int
);

  logic             en;
  logic             oneshot;
  logic             ie;
  logic [PS_W-1:0]  prescale;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] count;
  logic             pend;

  logic wr;
  logic wr_ctrl;
  logic wr_limit;
  logic wr_count;
  logic wr_status;
  logic tick;
  logic expire;
  logic ps_clr;
  logic unused_bits;

  assign wr        = bus.cs && bus.we;
  assign wr_ctrl   = wr && reg_hit(bus.addr, TMR_CTRL);
  assign wr_limit  = wr && reg_hit(bus.addr, TMR_LIMIT);
  assign wr_count  = wr && reg_hit(bus.addr, TMR_COUNT);
  assign wr_status = wr && reg_hit(bus.addr, TMR_STATUS);

  // Expiry compares the pre-edge COUNT, even when software rewrites it this cycle.
  assign expire = tick && (count >= limit);
  assign ps_clr = wr_ctrl && bus.wdata[TMR_EN] && !en;

  assign unused_bits = ^{bus.wdata, bus.addr[1:0]};

  timer_prescaler #(.PS_W(PS_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (ps_clr),
    .prescale (prescale),
    .tick     (tick)
  );

  // Software CTRL writes take priority over the one-shot auto-disable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en       <= 1'b0;
      oneshot  <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
    end else if (wr_ctrl) begin
      en       <= bus.wdata[TMR_EN];
      oneshot  <= bus.wdata[TMR_ONESHOT];
      ie       <= bus.wdata[TMR_IE];
      prescale <= bus.wdata[TMR_PS_LSB +: PS_W];
    end else if (expire && oneshot) begin
      en       <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      limit <= RST_LIMIT;
    end else if (wr_limit) begin
      limit <= bus.wdata[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wr_count) begin
      count <= bus.wdata[CNT_W-1:0];
    end else if (tick) begin
      count <= expire ? '0 : count + CNT_W'(1);
    end
  end

  // A simultaneous expiry beats the W1C so no interrupt is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (expire) begin
      pend <= 1'b1;
    end else if (wr_status && bus.wdata[0]) begin
      pend <= 1'b0;
    end
  end

  assign timer_int = pend && ie;

  always_comb begin
    bus.rdata = '0;
    if (bus.cs) begin
      if (reg_hit(bus.addr, TMR_CTRL)) begin
        bus.rdata[TMR_EN]               = en;
        bus.rdata[TMR_ONESHOT]          = oneshot;
        bus.rdata[TMR_IE]               = ie;
        bus.rdata[TMR_PS_LSB +: PS_W]   = prescale;
      end else if (reg_hit(bus.addr, TMR_LIMIT)) begin
        bus.rdata[CNT_W-1:0] = limit;
      end else if (reg_hit(bus.addr, TMR_COUNT)) begin
        bus.rdata[CNT_W-1:0] = count;
      end else begin
        bus.rdata[0] = pend;
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl with hand-computed expectations.
module tb_timer_ctrl;

  logic clk;
  logic reset;
  logic timer_int;
  int   total;
  int   bad;

  timer_ctrl_if bus ();

  timer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .timer_int (timer_int)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every bus access finishes 1 time unit after a rising edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.cs = 1'b1;
    bus.we = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.cs = 1'b0;
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.cs = 1'b1;
    bus.we = 1'b0;
    bus.addr = a;
    #1;
    d = bus.rdata;
    bus.cs = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    total++; if (timer_int !== 1'b0) begin bad++; $display("[TB] FAIL reset_int got=%b exp=0", timer_int); end
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_ctrl got=%h exp=%h", rd, 32'h0); end
    bus_read(4'h4, rd);
    total++; if (rd !== 32'd1000) begin bad++; $display("[TB] FAIL reset_limit got=%h exp=%h", rd, 32'd1000); end
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_count got=%h exp=%h", rd, 32'h0); end
    bus_read(4'hC, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_status got=%h exp=%h", rd, 32'h0); end
    bus.addr = 4'h4;
    #1;
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("[TB] FAIL read_no_cs got=%h exp=%h", bus.rdata, 32'h0); end
  endtask

  task automatic test_periodic();
    logic [31:0] rd;
    bus_write(4'h4, 32'd3);
    bus_write(4'h0, 32'h5);
    step(3);
    total++; if (timer_int !== 1'b0) begin bad++; $display("[TB] FAIL per_int_early got=%b exp=0", timer_int); end
    bus_read(4'h8, rd);
    total++; if (rd !== 32'd3) begin bad++; $display("[TB] FAIL per_count3 got=%h exp=%h", rd, 32'd3); end
    step(1);
    total++; if (timer_int !== 1'b1) begin bad++; $display("[TB] FAIL per_int_rise got=%b exp=1", timer_int); end
    bus_read(4'hC, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL per_pend got=%h exp=%h", rd, 32'h1); end
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL per_count_wrap got=%h exp=%h", rd, 32'h0); end
    bus_write(4'hC, 32'h1);
    total++; if (timer_int !== 1'b0) begin bad++; $display("[TB] FAIL per_w1c got=%b exp=0", timer_int); end
    step(2);
    total++; if (timer_int !== 1'b0) begin bad++; $display("[TB] FAIL per_int_gap got=%b exp=0", timer_int); end
    step(1);
    total++; if (timer_int !== 1'b1) begin bad++; $display("[TB] FAIL per_int_repeat got=%b exp=1", timer_int); end
    bus_write(4'h0, 32'h0);
    bus_write(4'hC, 32'h1);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL per_stop_count got=%h exp=%h", rd, 32'd1); end
    step(3);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL per_frozen got=%h exp=%h", rd, 32'd1); end
    total++; if (timer_int !== 1'b0) begin bad++; $display("[TB] FAIL per_stopped_int got=%b exp=0", timer_int); end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    bus_write(4'h8, 32'd0);
    bus_write(4'h4, 32'd1);
    bus_write(4'h0, 32'h207);
    step(5);
    total++; if (timer_int !== 1'b0) begin bad++; $display("[TB] FAIL os_int_early got=%b exp=0", timer_int); end
    bus_read(4'h8, rd);
    total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL os_count1 got=%h exp=%h", rd, 32'd1); end
    step(1);
    total++; if (timer_int !== 1'b1) begin bad++; $display("[TB] FAIL os_int got=%b exp=1", timer_int); end
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h206) begin bad++; $display("[TB] FAIL os_ctrl got=%h exp=%h", rd, 32'h206); end
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL os_count0 got=%h exp=%h", rd, 32'h0); end
    bus_write(4'hC, 32'h1);
    step(10);
    bus_read(4'hC, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL os_no_repend got=%h exp=%h", rd, 32'h0); end
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL os_count_stays got=%h exp=%h", rd, 32'h0); end
  endtask

  task automatic test_collisions();
    logic [31:0] rd;
    // LIMIT=0 expires every cycle, so any W1C lands on an expiry edge.
    bus_write(4'h4, 32'd0);
    bus_write(4'h0, 32'h5);
    step(2);
    bus_write(4'hC, 32'h1);
    bus_read(4'hC, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL col_w1c_vs_exp got=%h exp=%h", rd, 32'h1); end
    bus_write(4'h8, 32'd7);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'd7) begin bad++; $display("[TB] FAIL col_count_write got=%h exp=%h", rd, 32'd7); end
    bus_write(4'h0, 32'h0);
    bus_write(4'hC, 32'h1);
    bus_read(4'hC, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL col_cleared got=%h exp=%h", rd, 32'h0); end
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL col_count_exp got=%h exp=%h", rd, 32'h0); end
    // Write COUNT on the edge where the old COUNT reaches LIMIT=2.
    bus_write(4'h4, 32'd2);
    bus_write(4'h0, 32'h5);
    step(2);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'd2) begin bad++; $display("[TB] FAIL col_pre_count got=%h exp=%h", rd, 32'd2); end
    bus_write(4'h8, 32'd1);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL col_write_wins got=%h exp=%h", rd, 32'd1); end
    bus_read(4'hC, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL col_old_count_exp got=%h exp=%h", rd, 32'h1); end
    bus_write(4'h0, 32'h0);
    bus_write(4'hC, 32'h1);
  endtask

  task automatic test_ie_mask();
    logic [31:0] rd;
    bus_write(4'h8, 32'd0);
    bus_write(4'h4, 32'd1);
    bus_write(4'h0, 32'h1);
    step(1);
    bus_read(4'hC, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL ie_pre_pend got=%h exp=%h", rd, 32'h0); end
    step(1);
    bus_read(4'hC, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL ie_pend got=%h exp=%h", rd, 32'h1); end
    total++; if (timer_int !== 1'b0) begin bad++; $display("[TB] FAIL ie_masked got=%b exp=0", timer_int); end
    bus_write(4'h0, 32'h5);
    total++; if (timer_int !== 1'b1) begin bad++; $display("[TB] FAIL ie_unmask got=%b exp=1", timer_int); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    step(1);
    #2;
    reset = 1'b1;
    #1;
    total++; if (timer_int !== 1'b0) begin bad++; $display("[TB] FAIL ar_int got=%b exp=0", timer_int); end
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL ar_ctrl got=%h exp=%h", rd, 32'h0); end
    bus_read(4'h4, rd);
    total++; if (rd !== 32'd1000) begin bad++; $display("[TB] FAIL ar_limit got=%h exp=%h", rd, 32'd1000); end
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL ar_count got=%h exp=%h", rd, 32'h0); end
    bus_read(4'hC, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL ar_status got=%h exp=%h", rd, 32'h0); end
    step(1);
    reset = 1'b0;
    step(3);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL ar_idle_count got=%h exp=%h", rd, 32'h0); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.cs = 1'b0;
    bus.we = 1'b0;
    bus.addr = 4'h0;
    bus.wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_collisions();
    test_ie_mask();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
